// File: rtl/dds_freq_meter.sv
`default_nettype none
// ============================================================================
// Module : dds_freq_meter
// Counts sys_clk cycles over N mid-scale rising crossings of a sampled
// waveform, then divides to the equivalent 32-bit DDS frequency word.
// Option : define FREQ_METER_SIGNED_EN for two's-complement din (threshold 0).
// Rev    : 1.0
// ============================================================================
module dds_freq_meter #(
    parameter int CNT_W = 24,
    parameter int HYST  = 16,
    parameter int MID   = 2048
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       num_periods,
    input  logic [11:0]      din,
    input  logic             din_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic [31:0]      fword_est
);
    localparam int               DIV_BITS   = 40;
    localparam logic [5:0]       c_DIV_END  = 6'(DIV_BITS);
    localparam logic [CNT_W-1:0] c_CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_MEASURE    = 3'd2,
        S_DIVIDE     = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_armed;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_n;
    logic [7:0]          r_left;
    logic [5:0]          r_it;
    logic [CNT_W-1:0]    r_drem;
    logic [DIV_BITS-1:0] r_dq;

    logic                w_below;
    logic                w_above;
    logic                w_cross;
    logic                w_tmo;
    logic [CNT_W:0]      w_trial;
    logic                w_fit;
    logic [CNT_W-1:0]    w_diff;
    logic [31:0]         w_fword;

`ifdef FREQ_METER_SIGNED_EN
    localparam logic signed [12:0] c_ARM_LVL = 13'(-HYST);
    assign w_below = $signed({din[11], din}) < c_ARM_LVL;
    assign w_above = ~din[11];
`else
    localparam logic [12:0] c_ARM_LVL = 13'(MID - HYST);
    localparam logic [12:0] c_MID     = 13'(MID);
    assign w_below = {1'b0, din} < c_ARM_LVL;
    assign w_above = {1'b0, din} >= c_MID;
`endif

    assign w_cross = din_valid & r_armed & w_above;
    assign w_tmo   = (r_cnt == c_CNT_LAST);

    // Restoring divider: the remainder stays below the divisor, so the
    // low CNT_W bits of the subtraction are exact.
    assign w_trial = {r_drem, r_dq[DIV_BITS-1]};
    assign w_fit   = (w_trial >= {1'b0, period_cnt});
    assign w_diff  = w_trial[CNT_W-1:0] - period_cnt;
    assign w_fword = (|r_dq[DIV_BITS-1:32]) ? 32'hFFFF_FFFF : r_dq[31:0];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            r_n        <= 8'd0;
            r_left     <= 8'd0;
            r_it       <= 6'd0;
            r_drem     <= '0;
            r_dq       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            period_cnt <= '0;
            fword_est  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= (num_periods == 8'd0) ? 8'd1 : num_periods;
                        r_armed <= 1'b0;
                        r_cnt   <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_WAIT_FIRST;
                    end
                end
                S_WAIT_FIRST: begin
                    if (w_cross) begin
                        r_armed <= 1'b0;
                    end else if (din_valid && w_below) begin
                        r_armed <= 1'b1;
                    end
                    if (w_cross) begin
                        r_cnt   <= '0;
                        r_left  <= r_n;
                        r_state <= S_MEASURE;
                    end else if (w_tmo) begin
                        timeout    <= 1'b1;
                        period_cnt <= '0;
                        fword_est  <= 32'd0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (w_cross) begin
                        r_armed <= 1'b0;
                    end else if (din_valid && w_below) begin
                        r_armed <= 1'b1;
                    end
                    if (w_cross && (r_left == 8'd1)) begin
                        period_cnt <= r_cnt + 1'b1;
                        r_drem     <= '0;
                        r_dq       <= {r_n, 32'd0};
                        r_it       <= 6'd0;
                        r_state    <= S_DIVIDE;
                    end else if (w_tmo) begin
                        timeout    <= 1'b1;
                        period_cnt <= '0;
                        fword_est  <= 32'd0;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_cross) begin
                            r_left <= r_left - 1'b1;
                        end
                    end
                end
                S_DIVIDE: begin
                    // 40 quotient-bit cycles followed by one result-commit cycle.
                    if (r_it == c_DIV_END) begin
                        fword_est <= w_fword;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        r_it   <= r_it + 1'b1;
                        r_drem <= w_fit ? w_diff : w_trial[CNT_W-1:0];
                        r_dq   <= {r_dq[DIV_BITS-2:0], w_fit};
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dds_freq_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dds_freq_meter
// Sawtooth DDS stimulus checked against a crossing-timestamp reference model.
// Rev    : 1.0
// ============================================================================
module tb_dds_freq_meter;
    localparam int CNT_W = 12;
    localparam int HYST  = 16;
    localparam int MID   = 2048;
    localparam int LAT   = 41;
    localparam int TMO   = (1 << CNT_W) - 1;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             start       = 1'b0;
    logic [7:0]       num_periods = 8'd0;
    logic [11:0]      din         = 12'd0;
    logic             din_valid   = 1'b0;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] period_cnt;
    logic [31:0]      fword_est;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] phase    = 32'd0;
    bit          sq_hi    = 1'b0;
    logic [31:0] prev_fw  = 32'd0;
    int          got_pc;
    logic [31:0] got_fw;
    bit          got_tmo;

    always #5 clk = ~clk;

    dds_freq_meter #(
        .CNT_W(CNT_W),
        .HYST (HYST),
        .MID  (MID)
    ) u_dut (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_periods(num_periods),
        .din        (din),
        .din_valid  (din_valid),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .period_cnt (period_cnt),
        .fword_est  (fword_est)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // v is the offset-binary sample value; din carries it in the DUT's format.
    task automatic drive_sample(input logic [31:0] fw, input int noise, input int valid_pct,
                                input bit square, output int v);
        if (square) begin
            sq_hi = ~sq_hi;
            v = sq_hi ? 2056 : 2040;
        end else begin
            phase = phase + fw;
            v = int'(phase[31:20]);
            if (noise > 0) v = v + int'($urandom_range(2 * noise)) - noise;
            if (v < 0) v = 0;
            if (v > 4095) v = 4095;
        end
`ifdef FREQ_METER_SIGNED_EN
        din = 12'(v) ^ 12'h800;
`else
        din = 12'(v);
`endif
        din_valid = (int'($urandom_range(99)) < valid_pct);
    endtask

    task automatic measure(input string tag, input logic [31:0] fw, input logic [7:0] np,
                           input int noise, input int valid_pct, input bit square,
                           input bit poke, input bit abort);
        int          n;
        int          k;
        int          v;
        int          exp_done_k;
        int          dcount;
        int          deadline;
        int          xs[$];
        bit          armed;
        bit          seen;
        bit          exp_tmo;
        logic [63:0] exp_pc;
        logic [63:0] exp_fw;
        n = (np == 8'd0) ? 1 : int'(np);
        num_periods = np;
        start = 1'b1;
        drive_sample(fw, noise, valid_pct, square, v);
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_busy_start"}, 64'(busy), 64'd1);
        armed = 1'b0; seen = 1'b0; exp_tmo = 1'b0; exp_done_k = -1; k = 0;
        while (!seen && k < 3 * TMO) begin
            k++;
            start = poke && (xs.size() > 0) && (exp_done_k < 0) && (k == xs[0] + 5);
            drive_sample(fw, noise, valid_pct, square, v);
            if (exp_done_k < 0) begin
                if (din_valid && armed && v >= MID) begin
                    xs.push_back(k);
                    armed = 1'b0;
                end else if (din_valid && v < MID - HYST) begin
                    armed = 1'b1;
                end
                if (xs.size() == 0) deadline = TMO;
                else                deadline = xs[0] + TMO;
                if (xs.size() == n + 1) begin
                    exp_done_k = k + LAT;
                end else if (k == deadline) begin
                    exp_done_k = k;
                    exp_tmo = 1'b1;
                end
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (abort && !exp_tmo && exp_done_k > 0 && k == exp_done_k - 20) begin
                rst_n = 1'b0;
                #1;
                check_val({tag, "_rst_busy"},    64'(busy),       64'd0);
                check_val({tag, "_rst_done"},    64'(done),       64'd0);
                check_val({tag, "_rst_timeout"}, 64'(timeout),    64'd0);
                check_val({tag, "_rst_pc"},      64'(period_cnt), 64'd0);
                check_val({tag, "_rst_fw"},      64'(fword_est),  64'd0);
                dcount = 0;
                repeat (60) begin
                    @(posedge clk); #1;
                    if (done) dcount++;
                end
                check_val({tag, "_no_done"}, 64'(dcount), 64'd0);
                rst_n = 1'b1;
                prev_fw = 32'd0;
                return;
            end
            if (done) begin
                seen = 1'b1;
            end else if (exp_done_k > 0 && !exp_tmo && k == exp_done_k - 1) begin
                check_val({tag, "_fw_held"},   64'(fword_est), 64'(prev_fw));
                check_val({tag, "_busy_div"},  64'(busy),      64'd1);
            end
        end
        check_val({tag, "_done_cycle"}, 64'(k), 64'(exp_done_k));
        if (exp_tmo || xs.size() < n + 1) begin
            exp_pc = 64'd0;
            exp_fw = 64'd0;
        end else begin
            exp_pc = 64'(xs[n] - xs[0]);
            exp_fw = (64'(n) << 32) / exp_pc;
            if (exp_fw > 64'hFFFF_FFFF) exp_fw = 64'hFFFF_FFFF;
        end
        check_val({tag, "_busy_done"}, 64'(busy),       64'd0);
        check_val({tag, "_timeout"},   64'(timeout),    64'(exp_tmo));
        check_val({tag, "_pc"},        64'(period_cnt), exp_pc);
        check_val({tag, "_fw"},        64'(fword_est),  exp_fw);
        got_pc  = int'(period_cnt);
        got_fw  = fword_est;
        got_tmo = timeout;
        prev_fw = exp_fw[31:0];
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, "_done_pulse"},    64'(done), 64'd0);
        check_val({tag, "_start_in_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy",    64'(busy),       64'd0);
        check_val("reset_done",    64'(done),       64'd0);
        check_val("reset_timeout", 64'(timeout),    64'd0);
        check_val("reset_pc",      64'(period_cnt), 64'd0);
        check_val("reset_fw",      64'(fword_est),  64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        phase = $urandom();

        measure("dds4", 32'h0100_0000, 8'd4, 0, 100, 1'b0, 1'b0, 1'b0);
        check_val("dds4_pc_const", 64'(got_pc), 64'd1024);
        check_val("dds4_fw_const", 64'(got_fw), 64'h0100_0000);

        measure("n0", 32'h0040_0000, 8'd0, 0, 100, 1'b0, 1'b0, 1'b0);
        check_val("n0_pc_const", 64'(got_pc), 64'd1024);
        check_val("n0_fw_const", 64'(got_fw), 64'h0040_0000);

        measure("hyst", 32'd0, 8'd3, 0, 100, 1'b1, 1'b0, 1'b0);
        check_val("hyst_tmo_const", 64'(got_tmo), 64'd1);
        check_val("hyst_fw_const",  64'(got_fw),  64'd0);
        check_val("hyst_pc_const",  64'(got_pc),  64'd0);

        measure("noise", 32'h0100_0000, 8'd4, 8, 100, 1'b0, 1'b0, 1'b0);
        check_val("noise_pc_window", 64'((got_pc >= 1023) && (got_pc <= 1025)), 64'd1);

        measure("poke", 32'h0100_0000, 8'd4, 0, 100, 1'b0, 1'b1, 1'b0);
        check_val("poke_pc_const", 64'(got_pc), 64'd1024);

        measure("rst", 32'h0100_0000, 8'd4, 0, 100, 1'b0, 1'b0, 1'b1);
        measure("after_rst", 32'h0100_0000, 8'd2, 0, 100, 1'b0, 1'b0, 1'b0);
        check_val("after_rst_pc_const", 64'(got_pc), 64'd512);
        check_val("after_rst_fw_const", 64'(got_fw), 64'h0100_0000);

        for (int i = 0; i < 8; i++) begin
            int          rnp;
            int          rp;
            logic [31:0] rfw;
            rnp = int'($urandom_range(6));
            rp  = int'($urandom_range(3000 / ((rnp == 0) ? 1 : rnp), 20));
            rfw = 32'((64'd1 << 32) / 64'(rp)) + 32'($urandom_range(4000));
            measure($sformatf("rnd%0d", i), rfw, 8'(rnp), int'($urandom_range(8)),
                    int'($urandom_range(100, 75)), 1'b0, 1'($urandom_range(1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dds_freq_meter.md
Name: dds_freq_meter

Overview:
- Measures the frequency of a 12-bit sampled periodic waveform, such as DDS sine output looped back or from an ADC.
- Counts sys_clk cycles across N mid-scale rising crossings, then runs a sequential divide to produce the equivalent 32-bit DDS frequency word.
- The result can be fed straight back into a DDS Fword input. Sits on the same sys_clk domain as the DDS.

Parameters:
- CNT_W, 24, width of cycle counter; also sets the timeout limit of 2^CNT_W-1 cycles.
- HYST, 16, hysteresis in LSBs below mid-scale needed to re-arm crossing detection.
- MID, 2048, mid-scale threshold for unsigned input.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle measurement request; accepted only when busy=0
- num_periods  in  8  number of waveform periods to integrate; latched at start; 0 treated as 1
- din  in  12  waveform sample, unsigned offset binary
- din_valid  in  1  din qualifier; crossing logic updates only when 1
- busy  out  1  high from accepted start until the done cycle
- done  out  1  one-cycle pulse when the result is valid
- timeout  out  1  result flag: measurement aborted, held until next accepted start
- period_cnt  out  CNT_W  sys_clk cycles spanning N periods
- fword_est  out  32  floor(N*2^32/period_cnt), saturated

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, state IDLE, armed=0, counter 0.
  - Reset mid-measurement aborts it; no done pulse is issued.
- States: IDLE, WAIT_FIRST, MEASURE, DIVIDE, DONE.
- IDLE:
  - start=1 → latch N=max(num_periods,1), clear armed, counter and timeout; go to WAIT_FIRST next cycle.
  - busy=1 from the cycle after start.
- Arming and crossing detect (only on din_valid=1):
  - din < MID-HYST sets armed.
  - Crossing event = armed && din >= MID; the same cycle clears armed.
  - Samples in [MID-HYST, MID) leave armed unchanged.
- WAIT_FIRST:
  - Counter increments every cycle.
  - On the first crossing: counter←0, remaining←N, go to MEASURE.
- MEASURE:
  - Counter increments every sys_clk cycle, independent of din_valid.
  - Each crossing decrements remaining.
  - On the crossing that makes remaining 0: period_cnt←counter+1, i.e. cycles from first crossing to Nth subsequent crossing, inclusive of the end edge; go to DIVIDE.
- Timeout:
  - In WAIT_FIRST or MEASURE, counter reaching 2^CNT_W-1 → timeout=1, period_cnt←0, fword_est←0, go to DONE.
- DIVIDE:
  - Restoring divider, one quotient bit per cycle.
  - Dividend = N<<32 (40 bits), divisor = period_cnt; 40 iterations.
  - If the 40-bit quotient > 0xFFFFFFFF, fword_est←0xFFFFFFFF.
  - fword_est is updated only at the end of DIVIDE; the previous value is held during division.
- DONE:
  - done=1 for exactly one cycle, busy=0 in the same cycle; return to IDLE.
- Latency, last crossing → done: 41 cycles.
- start while busy=1 is ignored. start in the DONE cycle is ignored.
- period_cnt, fword_est and timeout are held until the next accepted start.
- period_cnt ≥ 2 is guaranteed by re-arm, so divide-by-zero cannot occur.

Optional Feature:
- Macro: FREQ_METER_SIGNED_EN.
- Defined:
  - din is two's complement; threshold is 0 instead of MID.
  - Arm when din < -HYST (signed compare); crossing = armed && din >= 0.
  - MID is unused.
- Undefined: unsigned behaviour as above.
- Timing and all other behaviour are identical.

Test Plan:
- DDS loopback, Fword=0x01000000 (256-clock period), din_valid=1, num_periods=4, start → done with period_cnt=1024, fword_est=0x01000000, timeout=0, done exactly 41 cycles after the 4th crossing.
- DDS loopback, Fword=0x00400000, num_periods=0 → treated as N=1; period_cnt=1024, fword_est=0x00400000.
- Square wave alternating din=2040/2056 (inside hysteresis) for 5000 cycles, CNT_W=12 → no crossings, timeout=1, fword_est=0, period_cnt=0, one done pulse at 4095 cycles after start.
- Fword=0x01000000 with ±8 LSB noise added near mid-scale, N=4 → period_cnt=1024±1, no spurious extra crossings.
- Second start pulse asserted during MEASURE → ignored, result equals first measurement. Start in the DONE cycle → no new measurement.
- rst_n pulsed low during DIVIDE → all outputs 0 immediately, no done pulse. A new start after release measures correctly.
